weight_fetch_ctrl: RTL and testbench

- Read-side master for the 100-bit weight SRAM (25 x 4-bit weights per word).
- On a start pulse, streams a contiguous range of words out of the SRAM and presents them to the compute array over a valid/ready interface.
- Absorbs the SRAM's one-cycle registered read latency with a small skid FIFO, so the array can apply backpressure without any word being lost or duplicated.

---
 rtl/weight_fetch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl
//   Read-side master for the weight SRAM. On an accepted start it streams
//   num_words consecutive words beginning at base_addr out of the SRAM and
//   hands them to the compute array over a valid/ready interface. A small
//   skid FIFO absorbs the SRAM's one-cycle read latency so that backpressure
//   never loses or duplicates a word.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle transfer request, honoured only in IDLE
//   base_addr         first SRAM word index (sampled on start acceptance)
//   num_words         number of words to fetch (sampled on start acceptance)
//   busy              high from start acceptance until done
//   done              one-cycle completion pulse
//   sram_csb          SRAM chip enable, active low (low = read this cycle)
//   sram_raddr        SRAM read address
//   sram_rdata        SRAM read data, valid the cycle after issue
//   w_valid, w_ready  output handshake
//   w_data            output weight word (FIFO head)
//   w_last            final word of the transfer, qualified by w_valid
module weight_fetch_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 100,
  parameter int CNT_WIDTH  = 17,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [FCNT_W:0] DEPTH_EXT = (FCNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issue_idx;
  logic [CNT_WIDTH-1:0]  pop_idx;
  logic                  pending;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]     fifo_count;

  logic accept, issue, last_issue, push, pop, credit_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept = (state == S_IDLE) && start;
  assign push   = pending;
  assign pop    = w_valid && w_ready;

  // Words already buffered plus the one in flight, less the one leaving
  // this cycle, must leave room for the read we are about to issue.
  assign credit_ok = ({1'b0, fifo_count} + {{FCNT_W{1'b0}}, pending})
                     < (DEPTH_EXT + {{FCNT_W{1'b0}}, pop});

  assign issue      = (state == S_FETCH) && (issue_idx < num_q) && credit_ok;
  assign last_issue = issue && (issue_idx == num_q - CNT_WIDTH'(1));

  assign sram_csb   = ~issue;
  assign sram_raddr = base_q + ADDR_WIDTH'(issue_idx);

  assign w_valid = (fifo_count != '0);
  assign w_data  = mem[rd_ptr];
  assign w_last  = w_valid && (pop_idx == num_q - CNT_WIDTH'(1));

  assign busy = accept || (state == S_FETCH) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_words == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (last_issue) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && w_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      num_q     <= '0;
      issue_idx <= '0;
      pop_idx   <= '0;
      pending   <= 1'b0;
    end else begin
      if (accept) begin
        base_q    <= base_addr;
        num_q     <= num_words;
        issue_idx <= '0;
        pop_idx   <= '0;
      end else begin
        if (issue) begin
          issue_idx <= issue_idx + CNT_WIDTH'(1);
        end
        if (pop) begin
          pop_idx <= pop_idx + CNT_WIDTH'(1);
        end
      end
      pending <= issue;
    end
  end

  // Skid FIFO: the registered SRAM output is captured the cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sram_rdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
      push |-> ((fifo_count < FCNT_W'(FIFO_DEPTH)) || pop)
  );

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
module tb_weight_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] base_addr;
  logic [16:0] num_words;
  logic        busy, done, sram_csb;
  logic [16:0] sram_raddr;
  logic [99:0] sram_rdata = '0;
  logic        w_valid, w_ready, w_last;
  logic [99:0] w_data;

  int checks = 0;
  int errors = 0;

  weight_fetch_ctrl #(
    .ADDR_WIDTH(17),
    .DATA_WIDTH(100),
    .CNT_WIDTH (17),
    .FIFO_DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .sram_csb  (sram_csb),
    .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_last    (w_last)
  );

  always #5 clk = ~clk;

  // SRAM contents: mem[i] = {25{i[3:0]}}
  function automatic logic [99:0] word_of(input logic [16:0] a);
    return {25{a[3:0]}};
  endfunction

  // Registered read: data for an issue in cycle T is visible in T+1.
  always @(posedge clk) begin
    if (!sram_csb) sram_rdata <= word_of(sram_raddr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; w_ready = 1'b0; base_addr = '0; num_words = '0;
    #3;
    checks++;
    if ({busy, done, sram_csb, w_valid, w_last} !== 5'b00100)
      begin errors++; $display("FAIL reset_ctrl got %b exp 00100", {busy, done, sram_csb, w_valid, w_last}); end
    checks++;
    if (sram_raddr !== 17'd0) begin errors++; $display("FAIL reset_raddr got %h exp 0", sram_raddr); end
    checks++;
    if (w_data !== 100'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", w_data); end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [16:0] a;
    tick();
    base_addr = 17'd21; num_words = 17'd4; start = 1'b1; w_ready = 1'b1;
    #1;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin tick(); start = 1'b0; #1; end
      checks++;
      if (sram_csb !== !(k >= 1 && k <= 4))
        begin errors++; $display("FAIL basic_csb k=%0d got %b exp %b", k, sram_csb, !(k >= 1 && k <= 4)); end
      if (k >= 1 && k <= 4) begin
        a = 17'(21 + k - 1);
        checks++;
        if (sram_raddr !== a) begin errors++; $display("FAIL basic_raddr k=%0d got %h exp %h", k, sram_raddr, a); end
      end
      checks++;
      if (w_valid !== (k >= 3 && k <= 6))
        begin errors++; $display("FAIL basic_valid k=%0d got %b exp %b", k, w_valid, (k >= 3 && k <= 6)); end
      if (k >= 3 && k <= 6) begin
        a = 17'(21 + k - 3);
        checks++;
        if (w_data !== word_of(a)) begin errors++; $display("FAIL basic_data k=%0d got %h exp %h", k, w_data, word_of(a)); end
        checks++;
        if (w_last !== (k == 6)) begin errors++; $display("FAIL basic_last k=%0d got %b exp %b", k, w_last, (k == 6)); end
      end
      checks++;
      if (done !== (k == 7)) begin errors++; $display("FAIL basic_done k=%0d got %b exp %b", k, done, (k == 7)); end
      checks++;
      if (busy !== (k <= 6)) begin errors++; $display("FAIL basic_busy k=%0d got %b exp %b", k, busy, (k <= 6)); end
    end
  endtask

  task automatic test_backpressure();
    int issued = 0, delivered = 0, dones = 0, last_hs = -10, done_c = -1;
    bit stalled = 0, fin = 0;
    logic [99:0] hold_d;
    logic hold_l;
    tick();
    base_addr = 17'd100; num_words = 17'd8; start = 1'b1; w_ready = 1'b1;
    #1;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (c > 0) begin
        tick(); start = 1'b0;
        w_ready = (c % 4 == 0) || (c % 4 == 3);
        #1;
      end
      if (stalled) begin
        checks++;
        if (w_valid !== 1'b1 || w_data !== hold_d || w_last !== hold_l)
          begin errors++; $display("FAIL bp_stable c=%0d got v%b l%b %h exp v1 l%b %h", c, w_valid, w_last, w_data, hold_l, hold_d); end
      end
      if (!sram_csb) begin
        checks++;
        if (sram_raddr !== 17'(100 + issued))
          begin errors++; $display("FAIL bp_raddr got %h exp %h", sram_raddr, 17'(100 + issued)); end
        issued++;
      end
      if (w_valid && w_ready) begin
        checks++;
        if (w_data !== word_of(17'(100 + delivered)) || w_last !== (delivered == 7))
          begin errors++; $display("FAIL bp_word n=%0d got %h l%b exp %h l%b", delivered, w_data, w_last, word_of(17'(100 + delivered)), (delivered == 7)); end
        delivered++;
        last_hs = c;
      end
      checks++;
      if (issued - delivered >= 4)
        begin errors++; $display("FAIL bp_outstanding got %0d exp <4", issued - delivered); end
      if (done) begin dones++; if (done_c < 0) done_c = c; end
      if (done_c >= 0 && c >= done_c + 3) fin = 1;
      stalled = w_valid && !w_ready;
      hold_d = w_data;
      hold_l = w_last;
    end
    w_ready = 1'b1;
    checks++;
    if (!fin) begin errors++; $display("FAIL bp_timeout got no done exp done"); end
    checks++;
    if (delivered != 8 || issued != 8)
      begin errors++; $display("FAIL bp_counts got del %0d iss %0d exp 8 8", delivered, issued); end
    checks++;
    if (dones != 1 || done_c != last_hs + 1)
      begin errors++; $display("FAIL bp_done got %0d pulses at %0d exp 1 at %0d", dones, done_c, last_hs + 1); end
  endtask

  task automatic test_zero();
    tick();
    base_addr = 17'd5; num_words = 17'd0; start = 1'b1; w_ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || sram_csb !== 1'b1)
      begin errors++; $display("FAIL zero_s got busy%b csb%b exp busy1 csb1", busy, sram_csb); end
    for (int k = 1; k <= 4; k++) begin
      tick(); start = 1'b0; #1;
      checks++;
      if ({done, busy, sram_csb, w_valid} !== {(k == 1), 1'b0, 1'b1, 1'b0})
        begin errors++; $display("FAIL zero_k%0d got %b exp %b", k, {done, busy, sram_csb, w_valid}, {(k == 1), 1'b0, 1'b1, 1'b0}); end
    end
  endtask

  task automatic test_wrap();
    logic [16:0] exp_a [3];
    int issued = 0, delivered = 0;
    bit fin = 0;
    exp_a[0] = 17'h1FFFE; exp_a[1] = 17'h1FFFF; exp_a[2] = 17'h00000;
    tick();
    base_addr = 17'h1FFFE; num_words = 17'd3; start = 1'b1; w_ready = 1'b1;
    #1;
    for (int c = 0; c < 20 && !fin; c++) begin
      if (c > 0) begin tick(); start = 1'b0; #1; end
      if (!sram_csb) begin
        checks++;
        if (issued > 2 || sram_raddr !== exp_a[issued % 3])
          begin errors++; $display("FAIL wrap_raddr n=%0d got %h exp %h", issued, sram_raddr, exp_a[issued % 3]); end
        issued++;
      end
      if (w_valid && w_ready) begin
        checks++;
        if (delivered > 2 || w_data !== word_of(exp_a[delivered % 3]))
          begin errors++; $display("FAIL wrap_data n=%0d got %h exp %h", delivered, w_data, word_of(exp_a[delivered % 3])); end
        delivered++;
      end
      if (done) fin = 1;
    end
    checks++;
    if (!fin || issued != 3 || delivered != 3)
      begin errors++; $display("FAIL wrap_end got fin%0d iss %0d del %0d exp 1 3 3", fin, issued, delivered); end
  endtask

  task automatic test_reset_mid();
    int delivered = 0, dones = 0;
    bit fin = 0;
    logic [16:0] a;
    tick();
    base_addr = 17'h200; num_words = 17'd16; start = 1'b1; w_ready = 1'b1;
    #1;
    tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sram_csb, w_valid, w_last} !== 5'b00100)
      begin errors++; $display("FAIL rmid_ctrl got %b exp 00100", {busy, done, sram_csb, w_valid, w_last}); end
    checks++;
    if (sram_raddr !== 17'd0 || w_data !== 100'd0)
      begin errors++; $display("FAIL rmid_data got %h %h exp 0 0", sram_raddr, w_data); end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      checks++;
      if (done !== 1'b0 || sram_csb !== 1'b1)
        begin errors++; $display("FAIL rmid_quiet got done%b csb%b exp done0 csb1", done, sram_csb); end
    end
    tick();
    base_addr = 17'd1100; num_words = 17'd2; start = 1'b1;
    #1;
    for (int c = 0; c < 20 && !fin; c++) begin
      if (c > 0) begin tick(); start = 1'b0; #1; end
      if (w_valid && w_ready) begin
        a = 17'(1100 + delivered);
        checks++;
        if (w_data !== word_of(a) || w_last !== (delivered == 1))
          begin errors++; $display("FAIL rmid_word n=%0d got %h l%b exp %h l%b", delivered, w_data, w_last, word_of(a), (delivered == 1)); end
        delivered++;
      end
      if (done) begin dones++; fin = 1; end
    end
    checks++;
    if (delivered != 2 || dones != 1)
      begin errors++; $display("FAIL rmid_end got del %0d done %0d exp 2 1", delivered, dones); end
  endtask

  task automatic test_start_busy();
    int issued = 0, delivered = 0, dones = 0, done_c = -1;
    bit fin = 0;
    tick();
    base_addr = 17'd300; num_words = 17'd10; start = 1'b1; w_ready = 1'b1;
    #1;
    for (int c = 0; c < 60 && !fin; c++) begin
      if (c > 0) begin
        tick();
        start = (c == 4);
        if (c == 4) begin base_addr = 17'd0; num_words = 17'd3; end
        #1;
      end
      if (!sram_csb) issued++;
      if (w_valid && w_ready) begin
        checks++;
        if (w_data !== word_of(17'(300 + delivered)) || w_last !== (delivered == 9))
          begin errors++; $display("FAIL sb_word n=%0d got %h l%b exp %h l%b", delivered, w_data, w_last, word_of(17'(300 + delivered)), (delivered == 9)); end
        delivered++;
      end
      if (done) begin dones++; if (done_c < 0) done_c = c; end
      if (done_c >= 0 && c >= done_c + 10) fin = 1;
    end
    checks++;
    if (!fin || delivered != 10 || issued != 10 || dones != 1)
      begin errors++; $display("FAIL sb_end got fin%0d del %0d iss %0d done %0d exp 1 10 10 1", fin, delivered, issued, dones); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
